// File: rtl/scr1_ialu_issue_ctrl.sv
// ----------------------------------------------------------------------------
// scr1_ialu_issue_ctrl
//
// Initiator side of the IALU request/response interface. Accepts one ALU
// command at a time from an upstream producer, presents it to scr1_pipe_ialu,
// waits for ialu_rdy on multicycle (MUL/DIV) ops, and returns the result and
// compare flag downstream. A watchdog turns a hung multicycle op into an
// error response instead of a deadlock.
//
// Ports
//   clk, rst                 single rising-edge clock, synchronous active-high reset
//   req_vd/req_rdy           upstream command handshake
//   req_op1/op2/cmd/mc       command operands, IALU command, multicycle flag
//   ialu_vd/op1/op2/cmd      registered request towards the IALU
//   ialu_res/cmp/rdy         IALU result, compare flag, multicycle done
//   rsp_vd/rsp_rdy           downstream response handshake
//   rsp_res/cmp/err          captured result, compare flag, watchdog error
// ----------------------------------------------------------------------------
module scr1_ialu_issue_ctrl #(
  parameter int XLEN    = 32,
  parameter int CMD_W   = 5,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  // upstream command
  input  logic             req_vd,
  output logic             req_rdy,
  input  logic [XLEN-1:0]  req_op1,
  input  logic [XLEN-1:0]  req_op2,
  input  logic [CMD_W-1:0] req_cmd,
  input  logic             req_mc,
  // IALU request / result
  output logic             ialu_vd,
  output logic [XLEN-1:0]  ialu_op1,
  output logic [XLEN-1:0]  ialu_op2,
  output logic [CMD_W-1:0] ialu_cmd,
  input  logic [XLEN-1:0]  ialu_res,
  input  logic             ialu_cmp,
  input  logic             ialu_rdy,
  // downstream response
  output logic             rsp_vd,
  input  logic             rsp_rdy,
  output logic [XLEN-1:0]  rsp_res,
  output logic             rsp_cmp,
  output logic             rsp_err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_WAIT,
    ST_RSP
  } state_t;

  state_t          state, state_nxt;
  logic            mc_q;
  logic [WD_W-1:0] wd, wd_nxt;

  logic            cap_en;
  logic [XLEN-1:0] cap_res;
  logic            cap_cmp;
  logic            cap_err;
  logic            accept;
  logic            rsp_done;

  // Handshake outputs are pure functions of state. req_rdy is also masked by
  // rst so the reset cycle never advertises readiness, even from IDLE.
  assign req_rdy  = (state == ST_IDLE) && !rst;
  assign ialu_vd  = (state == ST_EXEC) || (state == ST_WAIT);
  assign rsp_vd   = (state == ST_RSP);
  assign accept   = req_vd && req_rdy;
  assign rsp_done = rsp_vd && rsp_rdy;

  // NOTE: every signal driven here gets a default before the case statement,
  // so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    wd_nxt    = wd;
    cap_en    = 1'b0;
    cap_res   = ialu_res;
    cap_cmp   = ialu_cmp;
    cap_err   = 1'b0;

    case (state)
      ST_IDLE: begin
        wd_nxt = '0;
        if (accept) state_nxt = ST_EXEC;
      end

      ST_EXEC: begin
        // Single-cycle ops, and multicycle ops that finish immediately,
        // are captured straight out of EXEC.
        if (!mc_q || ialu_rdy) begin
          cap_en    = 1'b1;
          state_nxt = ST_RSP;
        end else begin
          wd_nxt    = WD_ONE;
          state_nxt = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // ialu_rdy is checked first so a completion on the very cycle the
        // watchdog expires still yields a good result.
        if (ialu_rdy) begin
          cap_en    = 1'b1;
          wd_nxt    = '0;
          state_nxt = ST_RSP;
        end else if (wd >= WD_LAST) begin
          cap_en    = 1'b1;
          cap_res   = '0;
          cap_cmp   = 1'b0;
          cap_err   = 1'b1;
          wd_nxt    = '0;
          state_nxt = ST_RSP;
        end else begin
          wd_nxt = wd + WD_ONE;
        end
      end

      ST_RSP: begin
        if (rsp_done) state_nxt = ST_IDLE;
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  // NOTE: every register here, including the datapath copies, is reset so
  // that outputs are defined zeros the cycle after reset and an in-flight
  // op leaves no trace.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      wd       <= '0;
      mc_q     <= 1'b0;
      ialu_op1 <= '0;
      ialu_op2 <= '0;
      ialu_cmd <= '0;
      rsp_res  <= '0;
      rsp_cmp  <= 1'b0;
      rsp_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      wd    <= wd_nxt;

      // Operands are only sampled on an accepted request, so they stay
      // stable for the whole EXEC/WAIT window.
      if (accept) begin
        ialu_op1 <= req_op1;
        ialu_op2 <= req_op2;
        ialu_cmd <= req_cmd;
        mc_q     <= req_mc;
      end

      if (cap_en) begin
        rsp_res <= cap_res;
        rsp_cmp <= cap_cmp;
        rsp_err <= cap_err;
      end else if (rsp_done) begin
        rsp_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_scr1_ialu_issue_ctrl.sv
// ----------------------------------------------------------------------------
// tb_scr1_ialu_issue_ctrl
//
// Randomized and directed stimulus for scr1_ialu_issue_ctrl. The driver
// pushes the expected response (value and arrival cycle) into a queue when a
// command is accepted; an independent monitor compares whatever the DUT
// presents against the queue head. The bench also plays the IALU: it returns
// a result from a small arithmetic model and raises ialu_rdy a chosen number
// of cycles into each multicycle op.
// ----------------------------------------------------------------------------
module tb_scr1_ialu_issue_ctrl;

  localparam int XLEN    = 32;
  localparam int CMD_W   = 5;
  localparam int TIMEOUT = 8;

  typedef struct {
    logic [XLEN-1:0] res;
    logic            cmp;
    logic            err;
    int              rsp_cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_vd = 1'b0;
  logic             req_rdy;
  logic [XLEN-1:0]  req_op1 = '0;
  logic [XLEN-1:0]  req_op2 = '0;
  logic [CMD_W-1:0] req_cmd = '0;
  logic             req_mc = 1'b0;
  logic             ialu_vd;
  logic [XLEN-1:0]  ialu_op1;
  logic [XLEN-1:0]  ialu_op2;
  logic [CMD_W-1:0] ialu_cmd;
  logic [XLEN-1:0]  ialu_res;
  logic             ialu_cmp;
  logic             ialu_rdy;
  logic             rsp_vd;
  logic             rsp_rdy = 1'b0;
  logic [XLEN-1:0]  rsp_res;
  logic             rsp_cmp;
  logic             rsp_err;

  scr1_ialu_issue_ctrl #(.XLEN(XLEN), .CMD_W(CMD_W), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_vd   (req_vd),
    .req_rdy  (req_rdy),
    .req_op1  (req_op1),
    .req_op2  (req_op2),
    .req_cmd  (req_cmd),
    .req_mc   (req_mc),
    .ialu_vd  (ialu_vd),
    .ialu_op1 (ialu_op1),
    .ialu_op2 (ialu_op2),
    .ialu_cmd (ialu_cmd),
    .ialu_res (ialu_res),
    .ialu_cmp (ialu_cmp),
    .ialu_rdy (ialu_rdy),
    .rsp_vd   (rsp_vd),
    .rsp_rdy  (rsp_rdy),
    .rsp_res  (rsp_res),
    .rsp_cmp  (rsp_cmp),
    .rsp_err  (rsp_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // --------------------------------------------------------------------------
  // IALU behavioural model: cmd[1:0] picks add/sub/xor/mul, compare is
  // unsigned less-than.
  // --------------------------------------------------------------------------
  function automatic logic [XLEN-1:0] alu_ref(input logic [CMD_W-1:0] c,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    case (c[1:0])
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a ^ b;
      default: return a * b;
    endcase
  endfunction

  // Details of the op currently in flight, set by the driver at acceptance.
  logic             cur_mc    = 1'b0;
  int               cur_delay = 0;
  logic [XLEN-1:0]  cur_op1   = '0;
  logic [XLEN-1:0]  cur_op2   = '0;
  logic [CMD_W-1:0] cur_cmd   = '0;
  int               op_cyc    = 0;
  logic             noise     = 1'b0;
  logic             force_noise = 1'b0;
  int               rsp_mode  = 0;   // 0: always ready, 1: random, 2: stalled
  int               last_acc  = 0;

  // ialu_rdy fires cur_delay cycles after ialu_vd rises for a multicycle op;
  // otherwise it carries random noise the DUT must ignore. While a
  // multicycle op has not completed the result bus carries garbage.
  always @(posedge clk) op_cyc <= ialu_vd ? op_cyc + 1 : 0;

  assign ialu_rdy = (ialu_vd && cur_mc) ? (op_cyc == cur_delay) : noise;
  assign ialu_res = (cur_mc && !ialu_rdy) ? 32'hDEAD_BEEF : alu_ref(ialu_cmd, ialu_op1, ialu_op2);
  assign ialu_cmp = (cur_mc && !ialu_rdy) ? 1'b1 : (ialu_op1 < ialu_op2);

  always @(posedge clk) begin
    #1;
    case (rsp_mode)
      0:       rsp_rdy = 1'b1;
      1:       rsp_rdy = 1'($urandom % 2);
      default: rsp_rdy = 1'b0;
    endcase
    noise = force_noise | 1'($urandom % 2);
  end

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  exp_t exp_q[$];
  bit   seen_vd = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      seen_vd = 1'b0;
    end else begin
      if (ialu_vd) begin
        check("ialu_operands", {ialu_op1, ialu_op2}, {cur_op1, cur_op2});
        check("ialu_cmd", 64'(ialu_cmd), 64'(cur_cmd));
      end
      if (rsp_vd) begin
        check("rsp_blocks_req_ialu", {62'd0, req_rdy, ialu_vd}, 64'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 64'd1, 64'd0);
        end else begin
          if (!seen_vd) begin
            check("rsp_latency", 64'(cyc), 64'(exp_q[0].rsp_cyc));
            seen_vd = 1'b1;
          end
          check("rsp_data", {rsp_err, rsp_cmp, rsp_res},
                {exp_q[0].err, exp_q[0].cmp, exp_q[0].res});
          if (rsp_rdy) begin
            void'(exp_q.pop_front());
            seen_vd = 1'b0;
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Driver helpers. Each is entered and left 1 time unit after a rising edge.
  // --------------------------------------------------------------------------
  task automatic issue(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [CMD_W-1:0] c, input logic mc, input int d);
    bit   done;
    exp_t e;
    done    = 1'b0;
    req_vd  = 1'b1;
    req_op1 = a;
    req_op2 = b;
    req_cmd = c;
    req_mc  = mc;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (req_rdy && !rst) begin
        if (mc && d >= TIMEOUT) begin
          e.res = '0; e.cmp = 1'b0; e.err = 1'b1; e.rsp_cyc = cyc + 1 + TIMEOUT;
        end else begin
          e.res = alu_ref(c, a, b); e.cmp = (a < b); e.err = 1'b0;
          e.rsp_cyc = mc ? cyc + 2 + d : cyc + 2;
        end
        exp_q.push_back(e);
        cur_mc    = mc;
        cur_delay = d;
        cur_op1   = a;
        cur_op2   = b;
        cur_cmd   = c;
        last_acc  = cyc;
        done      = 1'b1;
      end
    end
    if (!done) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    req_vd = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    req_vd = 1'b0;
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    #1;
  endtask

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    int prev_acc;
    bit got_vd;

    // Reset: two cycles, outputs checked in the second.
    @(posedge clk); #1;
    @(negedge clk);
    check("reset_req_rdy", 64'(req_rdy), 64'd0);
    check("reset_vd", {62'd0, ialu_vd, rsp_vd}, 64'd0);
    check("reset_ialu_regs", {ialu_op1, ialu_op2}, 64'd0);
    check("reset_rsp_regs", {rsp_err, rsp_cmp, rsp_res}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_req_rdy", 64'(req_rdy), 64'd1);
    @(posedge clk); #1;

    // Single-cycle ADD 5 + 7.
    rsp_mode = 0;
    issue(32'd5, 32'd7, 5'd0, 1'b0, 0);
    drain();

    // Multicycle MUL 6 * 7, ialu_rdy in the fourth ialu_vd cycle.
    issue(32'd6, 32'd7, 5'd3, 1'b1, 3);
    drain();

    // Backpressure: response held for five stalled cycles.
    rsp_mode = 2;
    issue(32'h1234_5678, 32'h0000_00FF, 5'd2, 1'b0, 0);
    req_vd = 1'b0;
    got_vd = 1'b0;
    for (int i = 0; i < 20 && !got_vd; i++) begin
      @(negedge clk);
      got_vd = rsp_vd;
    end
    check("bp_rsp_seen", 64'(got_vd), 64'd1);
    repeat (5) begin
      @(negedge clk);
      check("bp_rsp_held", 64'(rsp_vd), 64'd1);
    end
    rsp_mode = 0;
    @(posedge clk); #1;
    drain();

    // Watchdog: never ready, ready on the last allowed cycle, one cycle late,
    // then a clean op to show the error flag is gone.
    issue(32'd9, 32'd3, 5'd3, 1'b1, 1000);
    drain();
    issue(32'd11, 32'd4, 5'd1, 1'b1, TIMEOUT - 1);
    drain();
    issue(32'd11, 32'd4, 5'd1, 1'b1, TIMEOUT);
    drain();
    issue(32'd1, 32'd2, 5'd0, 1'b0, 0);
    drain();

    // Reset while in WAIT, with ialu_rdy high the following cycle.
    force_noise = 1'b1;
    issue(32'd77, 32'd88, 5'd3, 1'b1, 50);
    req_vd = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_wait_vd", 64'(ialu_vd), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_req_rdy", 64'(req_rdy), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rst_mid_outputs", {61'd0, ialu_vd, rsp_vd, rsp_err}, 64'd0);
    check("rst_mid_req_rdy_after", 64'(req_rdy), 64'd1);
    check("rst_mid_regs", {ialu_op1, rsp_res}, 64'd0);
    @(posedge clk); #1;
    repeat (6) begin
      @(negedge clk);
      check("rst_no_late_rsp", 64'(rsp_vd), 64'd0);
    end
    force_noise = 1'b0;
    @(posedge clk); #1;

    // Back-to-back single-cycle commands with req_vd held high.
    rsp_mode = 0;
    prev_acc = 0;
    for (int i = 0; i < 4; i++) begin
      issue(32'(100 + i), 32'(3 * i), 5'(i), 1'b0, 0);
      if (i > 0) check("b2b_spacing", 64'(last_acc - prev_acc), 64'd3);
      prev_acc = last_acc;
    end
    drain();

    // Random traffic.
    for (int i = 0; i < 200; i++) begin
      rsp_mode = int'($urandom % 2);
      issue($urandom, $urandom, 5'($urandom), 1'($urandom % 2),
            int'($urandom_range(0, TIMEOUT + 2)));
      if ($urandom % 3 != 0) idle(int'($urandom % 3));
    end
    rsp_mode = 0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
